// File: rtl/cache_pkg.sv
// Shared types and derived widths for the set-associative cache controller.
// The default-geometry constants match the 6/8/3/2 build.
package cache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WB,
      REFILL,
      INSTALL,
      RESP
   } state_t;

   // A single way still needs a one-bit age/way index.
   function automatic int age_width(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

   function automatic int tag_width(input int addr_w, input int set_bits);
      return addr_w - set_bits;
   endfunction

   localparam int DEF_ADDR_W   = 6;
   localparam int DEF_SET_BITS = 3;
   localparam int DEF_WAYS     = 2;
   localparam int TAG_W        = tag_width(DEF_ADDR_W, DEF_SET_BITS);
   localparam int AGE_W        = age_width(DEF_WAYS);

   typedef struct packed {
      logic valid;
      logic dirty;
   } line_flags_t;

endpackage

// File: rtl/cache_lru.sv
// Combinational true-LRU helper: picks a victim way for one set and computes
// that set's ages after the given way is touched.
module cache_lru
   import cache_pkg::*;
#(
   parameter int WAYS  = 2,
   parameter int IDX_W = 1
) (
   input  logic [WAYS-1:0]       valid,
   input  logic [WAYS*IDX_W-1:0] ages,
   input  logic [IDX_W-1:0]      access_way,
   output logic [IDX_W-1:0]      victim,
   output logic [WAYS*IDX_W-1:0] new_ages
);

   logic             found_invalid;
   logic [IDX_W-1:0] access_age;
   logic [IDX_W-1:0] cur_age;

   // Lowest invalid way wins; a full set gives up its oldest way.
   always_comb begin
      victim        = '0;
      found_invalid = 1'b0;
      for (int i = 0; i < WAYS; i++) begin
         if (!valid[i] && !found_invalid) begin
            victim        = IDX_W'(i);
            found_invalid = 1'b1;
         end
      end
      if (!found_invalid) begin
         for (int i = 0; i < WAYS; i++) begin
            if (ages[i*IDX_W +: IDX_W] == IDX_W'(WAYS - 1)) begin
               victim = IDX_W'(i);
            end
         end
      end
   end

   always_comb begin
      new_ages   = ages;
      cur_age    = '0;
      access_age = ages[int'(access_way)*IDX_W +: IDX_W];
      for (int i = 0; i < WAYS; i++) begin
         cur_age = ages[i*IDX_W +: IDX_W];
         if (IDX_W'(i) == access_way) begin
            new_ages[i*IDX_W +: IDX_W] = '0;
         end else if (cur_age < access_age) begin
            new_ages[i*IDX_W +: IDX_W] = cur_age + IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back/write-allocate cache with true LRU and a
// request/ack memory port. Define CACHE_STATS_EN to add hit/miss counters.
module set_assoc_cache
   import cache_pkg::*;
#(
   parameter int ADDR_W   = 6,
   parameter int DATA_W   = 8,
   parameter int SET_BITS = 3,
   parameter int WAYS     = 2
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              cpu_req,
   input  logic              cpu_rwb,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic              cpu_done,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_hit,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0]       hit_count,
   output logic [15:0]       miss_count
`endif
);

   localparam int SETS       = 1 << SET_BITS;
   localparam int LINE_TAG_W = tag_width(ADDR_W, SET_BITS);
   localparam int LINE_AGE_W = age_width(WAYS);

   state_t                state_q, state_d;
   logic                  req_rwb_q, req_rwb_d;
   logic [ADDR_W-1:0]     req_addr_q, req_addr_d;
   logic [DATA_W-1:0]     req_wdata_q, req_wdata_d;
   logic [LINE_AGE_W-1:0] way_q, way_d;
   logic                  hit_q, hit_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;
   logic [DATA_W-1:0]     fill_q, fill_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;

   line_flags_t           flags_q [SETS][WAYS];
   line_flags_t           flags_d [SETS][WAYS];
   logic [LINE_TAG_W-1:0] tags_q  [SETS][WAYS];
   logic [LINE_TAG_W-1:0] tags_d  [SETS][WAYS];
   logic [DATA_W-1:0]     data_q  [SETS][WAYS];
   logic [DATA_W-1:0]     data_d  [SETS][WAYS];
   logic [LINE_AGE_W-1:0] ages_q  [SETS][WAYS];
   logic [LINE_AGE_W-1:0] ages_d  [SETS][WAYS];

   logic [SET_BITS-1:0]        set_idx;
   logic [LINE_TAG_W-1:0]      req_tag;
   logic                       lookup_hit;
   logic [LINE_AGE_W-1:0]      hit_way;
   logic [LINE_AGE_W-1:0]      lru_access;
   logic [LINE_AGE_W-1:0]      lru_victim;
   logic [WAYS-1:0]            set_valid;
   logic [WAYS*LINE_AGE_W-1:0] set_ages;
   logic [WAYS*LINE_AGE_W-1:0] new_ages;

   assign set_idx    = req_addr_q[SET_BITS-1:0];
   assign req_tag    = req_addr_q[ADDR_W-1:SET_BITS];
   assign lru_access = (state_q == LOOKUP) ? hit_way : way_q;

   always_comb begin
      lookup_hit = 1'b0;
      hit_way    = '0;
      set_valid  = '0;
      set_ages   = '0;
      for (int w = 0; w < WAYS; w++) begin
         set_valid[w]                           = flags_q[set_idx][w].valid;
         set_ages[w*LINE_AGE_W +: LINE_AGE_W]   = ages_q[set_idx][w];
         if (flags_q[set_idx][w].valid && (tags_q[set_idx][w] == req_tag)) begin
            lookup_hit = 1'b1;
            hit_way    = LINE_AGE_W'(w);
         end
      end
   end

   cache_lru #(
      .WAYS (WAYS),
      .IDX_W(LINE_AGE_W)
   ) u_lru (
      .valid     (set_valid),
      .ages      (set_ages),
      .access_way(lru_access),
      .victim    (lru_victim),
      .new_ages  (new_ages)
   );

   // Memory outputs are computed one state ahead so they come straight from flops.
   always_comb begin
      state_d     = state_q;
      req_rwb_d   = req_rwb_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      way_d       = way_q;
      hit_d       = hit_q;
      rdata_d     = rdata_q;
      fill_d      = fill_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      flags_d     = flags_q;
      tags_d      = tags_q;
      data_d      = data_q;
      ages_d      = ages_q;

      case (state_q)
         IDLE: begin
            if (cpu_req) begin
               req_rwb_d   = cpu_rwb;
               req_addr_d  = cpu_addr;
               req_wdata_d = cpu_wdata;
               state_d     = LOOKUP;
            end
         end
         LOOKUP: begin
            hit_d = lookup_hit;
            if (lookup_hit) begin
               way_d = hit_way;
               if (req_rwb_q) begin
                  data_d[set_idx][hit_way]        = req_wdata_q;
                  flags_d[set_idx][hit_way].dirty = 1'b1;
                  rdata_d                         = req_wdata_q;
               end else begin
                  rdata_d = data_q[set_idx][hit_way];
               end
               for (int w = 0; w < WAYS; w++) begin
                  ages_d[set_idx][w] = new_ages[w*LINE_AGE_W +: LINE_AGE_W];
               end
               state_d = RESP;
            end else begin
               way_d = lru_victim;
               if (flags_q[set_idx][lru_victim].valid && flags_q[set_idx][lru_victim].dirty) begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = {tags_q[set_idx][lru_victim], set_idx};
                  mem_wdata_d = data_q[set_idx][lru_victim];
                  state_d     = WB;
               end else if (req_rwb_q) begin
                  state_d = INSTALL;
               end else begin
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = req_addr_q;
                  state_d    = REFILL;
               end
            end
         end
         WB: begin
            if (mem_req_q && mem_ack) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               state_d   = req_rwb_q ? INSTALL : REFILL;
            end
         end
         REFILL: begin
            // Coming from WB, the request drops for a cycle before the refill starts.
            if (!mem_req_q) begin
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = req_addr_q;
            end else if (mem_ack) begin
               fill_d    = mem_rdata;
               mem_req_d = 1'b0;
               state_d   = INSTALL;
            end
         end
         INSTALL: begin
            flags_d[set_idx][way_q].valid = 1'b1;
            flags_d[set_idx][way_q].dirty = req_rwb_q;
            tags_d[set_idx][way_q]        = req_tag;
            data_d[set_idx][way_q]        = req_rwb_q ? req_wdata_q : fill_q;
            rdata_d                       = req_rwb_q ? req_wdata_q : fill_q;
            for (int w = 0; w < WAYS; w++) begin
               ages_d[set_idx][w] = new_ages[w*LINE_AGE_W +: LINE_AGE_W];
            end
            state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         req_rwb_q   <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         way_q       <= '0;
         hit_q       <= 1'b0;
         rdata_q     <= '0;
         fill_q      <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               flags_q[s][w] <= '0;
               tags_q[s][w]  <= '0;
               data_q[s][w]  <= '0;
               ages_q[s][w]  <= LINE_AGE_W'(w);
            end
         end
      end else begin
         state_q     <= state_d;
         req_rwb_q   <= req_rwb_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         way_q       <= way_d;
         hit_q       <= hit_d;
         rdata_q     <= rdata_d;
         fill_q      <= fill_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         flags_q     <= flags_d;
         tags_q      <= tags_d;
         data_q      <= data_d;
         ages_q      <= ages_d;
      end
   end

   assign cpu_ready = (state_q == IDLE);
   assign cpu_done  = (state_q == RESP);
   assign cpu_hit   = (state_q == RESP) && hit_q;
   assign cpu_rdata = rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

`ifdef CACHE_STATS_EN
   logic [15:0] hit_cnt_q, hit_cnt_d;
   logic [15:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (state_q == LOOKUP) begin
         if (lookup_hit && (hit_cnt_q != 16'hFFFF)) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
         end
         if (!lookup_hit && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Self-checking bench for set_assoc_cache (default 6/8/3/2 geometry) with a
// latency-configurable backing memory; stats checks apply when CACHE_STATS_EN is set.
module tb_set_assoc_cache;

   typedef struct {
      logic       rwb;
      logic [5:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
      logic       exp_hit;
      logic       has_wb;
      logic [5:0] wb_addr;
      logic [7:0] wb_data;
      logic       has_refill;
      int         lat_issue;
      logic       lat_ack;
   } vec_t;

   typedef struct {
      logic [7:0] rdata;
      logic       hit;
      int         lat_issue;
      logic       lat_ack;
   } exp_t;

   typedef struct {
      logic       we;
      logic [5:0] addr;
      logic [7:0] wdata;
      int         cycles;
      logic       stable;
   } txn_t;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       cpu_req, cpu_rwb;
   logic [5:0] cpu_addr;
   logic [7:0] cpu_wdata;
   logic       cpu_ready, cpu_done, cpu_hit;
   logic [7:0] cpu_rdata;
   logic       mem_req, mem_we;
   logic [5:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_ack;
   logic [7:0] mem_rdata;
`ifdef CACHE_STATS_EN
   logic [15:0] hit_count, miss_count;
`endif

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   issue_cycle = 0;
   int   last_ack_cyc = 0;
   int   ack_delay = 1;
   int   cur_op = 0;
   exp_t sb_q[$];
   txn_t txn_q[$];
   exp_t mon_e;
   logic [7:0] mem_model [64];
   vec_t vecs [12];

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   set_assoc_cache #(
      .ADDR_W(6), .DATA_W(8), .SET_BITS(3), .WAYS(2)
   ) dut (
      .Clk(Clk), .Reset(Reset),
      .cpu_req(cpu_req), .cpu_rwb(cpu_rwb), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic vec_t mk(input logic rwb, input logic [5:0] addr, input logic [7:0] wdata,
                               input logic [7:0] exp_rdata, input logic exp_hit,
                               input logic has_wb, input logic [5:0] wb_addr, input logic [7:0] wb_data,
                               input logic has_refill, input int lat_issue, input logic lat_ack);
      vec_t v;
      v.rwb = rwb; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_hit = exp_hit;
      v.has_wb = has_wb; v.wb_addr = wb_addr; v.wb_data = wb_data;
      v.has_refill = has_refill; v.lat_issue = lat_issue; v.lat_ack = lat_ack;
      return v;
   endfunction

   // Backing memory: acks ack_delay cycles after it first sees mem_req and logs each transfer.
   initial begin
      int   req_cnt;
      txn_t t;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      req_cnt   = 0;
      t         = '{1'b0, 6'h0, 8'h0, 0, 1'b1};
      for (int a = 0; a < 64; a++) mem_model[a] = 8'(a) ^ 8'hA0;
      forever begin
         @(posedge Clk);
         #1;
         mem_ack = 1'b0;
         if (Reset || !mem_req) begin
            req_cnt = 0;
         end else begin
            if (req_cnt == 0) begin
               t.we = mem_we; t.addr = mem_addr; t.wdata = mem_wdata; t.stable = 1'b1;
            end else if (mem_we != t.we || mem_addr != t.addr || (mem_we && mem_wdata != t.wdata)) begin
               t.stable = 1'b0;
            end
            req_cnt++;
            if (req_cnt > ack_delay) begin
               mem_ack = 1'b1;
               if (mem_we) mem_model[mem_addr] = mem_wdata;
               else mem_rdata = mem_model[mem_addr];
               t.cycles = req_cnt;
               txn_q.push_back(t);
               last_ack_cyc = cyc;
               req_cnt = 0;
            end
         end
      end
   end

   // Scoreboard: every completion pops the expectation pushed when its request was driven.
   always @(negedge Clk) begin
      if (!Reset && cpu_done === 1'b1) begin
         if (sb_q.size() == 0) begin
            checkOutput("unexpected_done", 32'd1, 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            checkOutput($sformatf("op%0d_rdata", cur_op), 32'(cpu_rdata), 32'(mon_e.rdata));
            checkOutput($sformatf("op%0d_hit", cur_op), 32'(cpu_hit), 32'(mon_e.hit));
            if (mon_e.lat_issue != 0)
               checkOutput($sformatf("op%0d_lat", cur_op), 32'(cyc - issue_cycle), 32'(mon_e.lat_issue));
            if (mon_e.lat_ack)
               checkOutput($sformatf("op%0d_ack_lat", cur_op), 32'(cyc - last_ack_cyc), 32'd2);
         end
      end
   end

   task automatic waitReady();
      int k;
      for (k = 0; k < 50 && cpu_ready !== 1'b1; k++) @(negedge Clk);
      if (cpu_ready !== 1'b1) checkOutput("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic waitDone();
      int k;
      for (k = 0; k < 200 && cpu_done !== 1'b1; k++) @(negedge Clk);
      if (cpu_done !== 1'b1) checkOutput($sformatf("op%0d_done_timeout", cur_op), 32'd0, 32'd1);
   endtask

   task automatic pushExpect(input logic [7:0] rdata, input logic hit, input int lat_issue, input logic lat_ack);
      exp_t e;
      e.rdata = rdata; e.hit = hit; e.lat_issue = lat_issue; e.lat_ack = lat_ack;
      sb_q.push_back(e);
   endtask

   task automatic checkTxn(input string name, input logic we, input logic [5:0] addr,
                           input logic [7:0] wdata, input int cycles);
      txn_t t;
      t = txn_q.pop_front();
      checkOutput({name, "_we"}, 32'(t.we), 32'(we));
      checkOutput({name, "_addr"}, 32'(t.addr), 32'(addr));
      if (we) checkOutput({name, "_wdata"}, 32'(t.wdata), 32'(wdata));
      checkOutput({name, "_stable"}, 32'(t.stable), 32'd1);
      if (cycles != 0) checkOutput({name, "_cycles"}, 32'(t.cycles), 32'(cycles));
   endtask

   task automatic applyStimulus(input vec_t v);
      int n;
      waitReady();
      txn_q.delete();
      pushExpect(v.exp_rdata, v.exp_hit, v.lat_issue, v.lat_ack);
      issue_cycle = cyc;
      cpu_req = 1'b1; cpu_rwb = v.rwb; cpu_addr = v.addr; cpu_wdata = v.wdata;
      @(negedge Clk);
      cpu_req = 1'b0;
      waitDone();
      @(negedge Clk);
      n = int'(v.has_wb) + int'(v.has_refill);
      checkOutput($sformatf("op%0d_txn_count", cur_op), 32'(txn_q.size()), 32'(n));
      if (txn_q.size() == n) begin
         if (v.has_wb) checkTxn($sformatf("op%0d_wb", cur_op), 1'b1, v.wb_addr, v.wb_data, 0);
         if (v.has_refill) checkTxn($sformatf("op%0d_refill", cur_op), 1'b0, v.addr, 8'h00, 0);
      end
   endtask

   initial begin
      logic ready_leak;
      int   k;
      Reset = 1'b1; cpu_req = 1'b0; cpu_rwb = 1'b0; cpu_addr = '0; cpu_wdata = '0;

      //           rwb addr   wdata  rdata  hit wb wb_addr wb_data rf lat ack
      vecs[0]  = mk(0, 6'h05, 8'h00, 8'hA5, 0, 0, 6'h00, 8'h00, 1, 0, 1);
      vecs[1]  = mk(0, 6'h05, 8'h00, 8'hA5, 1, 0, 6'h00, 8'h00, 0, 2, 0);
      vecs[2]  = mk(1, 6'h0D, 8'h3C, 8'h3C, 0, 0, 6'h00, 8'h00, 0, 3, 0);
      vecs[3]  = mk(0, 6'h15, 8'h00, 8'hB5, 0, 0, 6'h00, 8'h00, 1, 0, 1);
      vecs[4]  = mk(0, 6'h1D, 8'h00, 8'hBD, 0, 1, 6'h0D, 8'h3C, 1, 0, 1);
      vecs[5]  = mk(0, 6'h0D, 8'h00, 8'h3C, 0, 0, 6'h00, 8'h00, 1, 0, 1);
      vecs[6]  = mk(1, 6'h0D, 8'h77, 8'h77, 1, 0, 6'h00, 8'h00, 0, 2, 0);
      vecs[7]  = mk(0, 6'h1D, 8'h00, 8'hBD, 1, 0, 6'h00, 8'h00, 0, 2, 0);
      vecs[8]  = mk(0, 6'h25, 8'h00, 8'h85, 0, 1, 6'h0D, 8'h77, 1, 0, 1);
      vecs[9]  = mk(0, 6'h1D, 8'h00, 8'hBD, 1, 0, 6'h00, 8'h00, 0, 2, 0);
      vecs[10] = mk(1, 6'h02, 8'h5A, 8'h5A, 0, 0, 6'h00, 8'h00, 0, 3, 0);
      vecs[11] = mk(0, 6'h02, 8'h00, 8'h5A, 1, 0, 6'h00, 8'h00, 0, 2, 0);

      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      checkOutput("rst_ready", 32'(cpu_ready), 32'd1);
      checkOutput("rst_done", 32'(cpu_done), 32'd0);
      checkOutput("rst_hit", 32'(cpu_hit), 32'd0);
      checkOutput("rst_rdata", 32'(cpu_rdata), 32'd0);
      checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
      checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
      checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
      checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
`ifdef CACHE_STATS_EN
      checkOutput("rst_hit_count", 32'(hit_count), 32'd0);
      checkOutput("rst_miss_count", 32'(miss_count), 32'd0);
`endif

      for (int i = 0; i < 12; i++) begin
         cur_op = i;
         applyStimulus(vecs[i]);
`ifdef CACHE_STATS_EN
         if (i == 1) begin
            checkOutput("stats_hit_count", 32'(hit_count), 32'd1);
            checkOutput("stats_miss_count", 32'(miss_count), 32'd1);
         end
`endif
      end

      // Slow memory: request held stable for 7 cycles, busy-time request ignored.
      cur_op = 12;
      ack_delay = 6;
      waitReady();
      txn_q.delete();
      pushExpect(8'h93, 1'b0, 0, 1'b1);
      issue_cycle = cyc;
      cpu_req = 1'b1; cpu_rwb = 1'b0; cpu_addr = 6'h33; cpu_wdata = 8'h00;
      @(negedge Clk);
      cpu_req = 1'b0;
      ready_leak = 1'b0;
      for (k = 0; k < 100 && cpu_done !== 1'b1; k++) begin
         if (cpu_ready !== 1'b0) ready_leak = 1'b1;
         if (k == 3) begin
            cpu_req = 1'b1; cpu_rwb = 1'b1; cpu_addr = 6'h0A; cpu_wdata = 8'hEE;
         end else begin
            cpu_req = 1'b0;
         end
         @(negedge Clk);
      end
      cpu_req = 1'b0;
      checkOutput("slow_done_seen", 32'(cpu_done), 32'd1);
      checkOutput("slow_ready_low", 32'(ready_leak), 32'd0);
      repeat (6) @(negedge Clk);
      checkOutput("slow_txn_count", 32'(txn_q.size()), 32'd1);
      if (txn_q.size() == 1) checkTxn("slow_refill", 1'b0, 6'h33, 8'h00, 7);
      checkOutput("slow_sb_empty", 32'(sb_q.size()), 32'd0);
      ack_delay = 1;
      cur_op = 13;
      applyStimulus(mk(0, 6'h0A, 8'h00, 8'hAA, 0, 0, 6'h00, 8'h00, 1, 0, 1));

      // Reset in the middle of a writeback abandons it with no completion.
      cur_op = 14;
      applyStimulus(mk(1, 6'h0D, 8'h11, 8'h11, 0, 0, 6'h00, 8'h00, 0, 3, 0));
      cur_op = 15;
      applyStimulus(mk(0, 6'h2D, 8'h00, 8'h8D, 0, 0, 6'h00, 8'h00, 1, 0, 1));
      cur_op = 16;
      ack_delay = 4;
      waitReady();
      txn_q.delete();
      cpu_req = 1'b1; cpu_rwb = 1'b0; cpu_addr = 6'h3D; cpu_wdata = 8'h00;
      @(negedge Clk);
      cpu_req = 1'b0;
      for (k = 0; k < 20 && !(mem_req === 1'b1 && mem_we === 1'b1); k++) @(negedge Clk);
      checkOutput("abort_wb_seen", 32'(mem_req && mem_we), 32'd1);
      checkOutput("abort_wb_addr", 32'(mem_addr), 32'h0D);
      checkOutput("abort_wb_data", 32'(mem_wdata), 32'h11);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      checkOutput("abort_mem_req", 32'(mem_req), 32'd0);
      checkOutput("abort_ready", 32'(cpu_ready), 32'd1);
      checkOutput("abort_done", 32'(cpu_done), 32'd0);
`ifdef CACHE_STATS_EN
      checkOutput("abort_hit_count", 32'(hit_count), 32'd0);
      checkOutput("abort_miss_count", 32'(miss_count), 32'd0);
`endif
      repeat (5) @(negedge Clk);
      checkOutput("abort_no_txn", 32'(txn_q.size()), 32'd0);
      ack_delay = 1;
      cur_op = 17;
      applyStimulus(mk(0, 6'h0D, 8'h00, 8'h77, 0, 0, 6'h00, 8'h00, 1, 0, 1));

      repeat (3) @(negedge Clk);
      checkOutput("final_sb_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/set_assoc_cache.md
# set_assoc_cache

Parametrised N-way set-associative, write-back, write-allocate cache controller with true-LRU replacement. It is the successor of the fixed 2-way, 8-set, 8-bit processor-side cache. It sits between the processor and the backing RAM. Unlike its predecessor, it adds:
- a request/ready/done handshake on the processor side;
- a multi-cycle request/acknowledge handshake on the memory side, tolerating arbitrary memory latency;
- optional hit/miss statistics.

## Interface
Parameters:
- ADDR_W, default 6: processor word-address width.
- DATA_W, default 8: word width. One word per line.
- SET_BITS, default 3: log2 of the set count. Tag width is ADDR_W-SET_BITS.
- WAYS, default 2: associativity. Must be a power of two, 1..8.

Ports (one clock; reset is synchronous and active-high):
- Clk, in, 1: clock. All state updates on the rising edge.
- Reset, in, 1: synchronous, active-high reset.
- cpu_req, in, 1: request valid. Sampled only while cpu_ready=1.
- cpu_rwb, in, 1: 1=write, 0=read.
- cpu_addr, in, ADDR_W: word address.
- cpu_wdata, in, DATA_W: write data.
- cpu_ready, out, 1: high only in IDLE.
- cpu_done, out, 1: one-cycle completion pulse.
- cpu_rdata, out, DATA_W: read data. Valid with cpu_done; holds its value until the next done.
- cpu_hit, out, 1: hit flag for the completed access. Valid with cpu_done.
- mem_req, out, 1: memory request. Held until acknowledged.
- mem_we, out, 1: 1=writeback, 0=refill read.
- mem_addr, out, ADDR_W: memory address.
- mem_wdata, out, DATA_W: writeback data.
- mem_ack, in, 1: one-cycle acknowledge. For reads, mem_rdata is valid in the same cycle.
- mem_rdata, in, DATA_W: refill data.
- hit_count, out, 16: present only with CACHE_STATS_EN.
- miss_count, out, 16: present only with CACHE_STATS_EN.

## Operation
Per-line state: valid, dirty, tag, data, and an age of log2(WAYS) bits.

Address split: set = cpu_addr[SET_BITS-1:0], tag = cpu_addr[ADDR_W-1:SET_BITS].

The request (rwb, addr, wdata) is latched at accept.

FSM states:
- IDLE: cpu_ready=1. On cpu_req, latch the request and go to LOOKUP.
- LOOKUP: compare the tag against all valid ways of the set. At most one way may match.
  - Hit, read: capture the line data.
  - Hit, write: overwrite the line data and set dirty=1.
  - After either hit, update LRU and go to RESP.
  - Miss: select the victim (see LRU rules below). If the victim is valid and dirty, go to WB. Otherwise, a read miss goes to REFILL and a write miss goes to INSTALL.
- WB: mem_req=1, mem_we=1, mem_addr={victim tag, set}, mem_wdata=victim data. On mem_ack, a read goes to REFILL and a write goes to INSTALL.
- REFILL: mem_req=1, mem_we=0, mem_addr=latched address. On mem_ack, capture mem_rdata and go to INSTALL.
- INSTALL: write the victim way.
  - Read: valid=1, dirty=0, data=refill data.
  - Write: valid=1, dirty=1, data=wdata. There is no refill read, because the whole line is overwritten.
  - Update LRU and go to RESP.
- RESP: cpu_done=1. cpu_hit reflects the LOOKUP result. cpu_rdata is the line data (read) or the written data (write). Go to IDLE.

LRU rules:
- Victim is the lowest-index invalid way if one exists; otherwise the way with age WAYS-1.
- On access or install to way k: every way whose age is less than age_k increments; age_k becomes 0.
- Ages within a set always remain a permutation of 0..WAYS-1.

## Timing
- Hit: accept at T, LOOKUP at T+1, cpu_done at T+2. cpu_ready returns high at T+3.
- Clean read miss: cpu_done 2 cycles after the refill mem_ack cycle.
- Dirty miss: writeback, then refill (read) or install (write).
- mem_req/mem_we/mem_addr/mem_wdata are registered and stable from assertion through the mem_ack cycle. mem_req drops the cycle after mem_ack.
- cpu_req while cpu_ready=0 is ignored. It is not queued.
- Reset values:
  - State IDLE.
  - cpu_ready=1.
  - cpu_done, cpu_hit, mem_req, mem_we = 0.
  - cpu_rdata, mem_addr, mem_wdata = 0.
  - All valid/dirty = 0.
  - Age of way i = i.
  - Counters = 0.
- Reset mid-operation (any state): the same values apply on the next edge. The outstanding memory transaction is abandoned, dirty data is lost, and no cpu_done is issued.

## Configuration
- CACHE_STATS_EN defined:
  - hit_count increments in LOOKUP on a hit.
  - miss_count increments in LOOKUP on a miss.
  - Both saturate at 16'hFFFF and are cleared by Reset.
- CACHE_STATS_EN undefined: the counters and their ports are absent. Behaviour is otherwise identical.

## Structure
- Package cache_pkg:
  - FSM state enum (IDLE, LOOKUP, WB, REFILL, INSTALL, RESP).
  - Line-entry struct.
  - Derived width constants (TAG_W, AGE_W).
- Sub-module cache_lru:
  - Combinational.
  - Inputs: a set's valid vector and ages, plus the accessed way.
  - Outputs: victim index and updated ages.
- The tag/data arrays are registers inside set_assoc_cache.

## Test plan
Defaults (6/8/3/2), mem_ack 1 cycle after mem_req unless stated.
1. Reset, read 0x05 with mem_rdata=0xA5 -> one REFILL at mem_addr 0x05; done with rdata=0xA5, hit=0. Reading 0x05 again -> done at T+2, hit=1, no mem_req.
2. Write 0x0D=0x3C (miss) -> no memory traffic, installed dirty. Then read 0x15 -> evicts clean way0 with no writeback. Then read 0x1D -> WB with mem_addr=0x0D, mem_wdata=0x3C, then REFILL at 0x1D.
3. Write-hit 0x0D=0x77, then evict it -> writeback carries 0x77. LRU keeps the most recently touched way.
4. mem_ack delayed 6 cycles -> mem_req/mem_addr stable for all 7 cycles. cpu_ready=0 throughout, and a cpu_req pulse in that window is ignored.
5. Reset asserted during WB -> next cycle mem_req=0, cpu_ready=1, no cpu_done. A subsequent read of 0x0D misses.
6. With CACHE_STATS_EN, scenario 1 -> hit_count=1, miss_count=1.
